analog_trace_capture: RTL and testbench
=======================================

# analog_trace_capture

Trigger-based capture buffer for probed fixed-point analog signals in the emulator. It records `in_data` samples whenever `in_valid` is high and keeps a circular pre-trigger history. A rising-level crossing or a forced trigger freezes the buffer, and the frozen window is then streamed out oldest-first over a valid/ready port. It sits on the probe side of a filter testbench, consuming `v_out` with the same signed fixed-point width as the real-number macros, and feeds the host readout path.

## Interface
- `WIDTH`, 25: signed fixed-point sample width; must equal the width of the probed real.
- `DEPTH`, 256: samples per capture; power of two, at least 4.
- `PRE_TRIG`, 64: samples kept before the trigger sample; 0 ≤ PRE_TRIG < DEPTH.
- `emu_clk` in 1: emulator clock; all logic is rising-edge.
- `emu_rst` in 1: asynchronous, active-high reset.
- `in_data` in WIDTH: signed sample.
- `in_valid` in 1: sample strobe, one emulator time step.
- `arm` in 1: single-cycle pulse that starts a capture.
- `trig_level` in WIDTH: signed trigger threshold.
- `force_trig` in 1: triggers on the next accepted sample, regardless of level.
- `rd_data` out WIDTH: readout sample.
- `rd_valid` out 1: `rd_data` holds a valid sample.
- `rd_ready` in 1: consumer accepts the sample.
- `rd_last` out 1: marks the final sample of the window.
- `busy` out 1: state is not IDLE.
- `triggered` out 1: trigger has occurred in this capture.
- `done` out 1: state is READ.

## Operation
- States: IDLE, PRE, WAIT, POST, READ.
- IDLE → PRE on `arm`. Clears the sample counter, `prev_valid` and `triggered`. `arm` is ignored in every other state.
- PRE: each accepted sample (`in_valid`=1) is written at `wr_ptr`, then `wr_ptr` increments modulo DEPTH. After PRE_TRIG accepted samples, go to WAIT. With PRE_TRIG=0, go straight from IDLE to WAIT.
- Trigger condition, evaluated only on accepted samples in WAIT:
  - `force_trig` is high, or
  - `prev_valid` is set, `prev` < `trig_level`, and `in_data` ≥ `trig_level` (signed comparison).
- `prev` and `prev_valid` update on every accepted sample in PRE, WAIT and POST.
- Triggers are not evaluated in PRE.
- WAIT keeps writing circularly, so the history is always the most recent PRE_TRIG samples.
- On a trigger:
  - the trigger sample is written;
  - `trig_ptr` latches its address;
  - `triggered` is set;
  - go to POST with the post counter set to DEPTH−PRE_TRIG−1.
- If that counter is 0, go directly to READ.
- POST: each accepted sample is written and decrements the counter. When it reaches 0 after a write, go to READ.
- READ:
  - Read address starts at (`trig_ptr` − PRE_TRIG) mod DEPTH and walks forward DEPTH entries, wrapping.
  - `in_valid` is ignored.
  - After the transfer with `rd_last`=1, go to IDLE. `triggered` stays set until the next `arm`.
- Storage is one DEPTH×WIDTH simple dual-port RAM with synchronous read; BRAM inference is permitted.

## Timing
- Reset values:
  - outputs: `rd_valid`=0, `rd_last`=0, `rd_data`=0, `busy`=0, `triggered`=0, `done`=0;
  - internal: state=IDLE, pointers=0, `prev_valid`=0.
- Write latency: a sample accepted on edge N is stored at edge N.
- State transitions take effect on the same edge as the qualifying sample.
- `busy` rises one cycle after the `arm` edge.
- `done` and `rd_valid`:
  - `done` is high in the first READ cycle;
  - `rd_valid` first asserts no later than 2 cycles after entering READ (RAM prefetch).
- Read handshake:
  - A transfer happens when `rd_valid`&&`rd_ready`.
  - `rd_data` and `rd_last` hold stable while `rd_valid`=1 and `rd_ready`=0.
  - With `rd_ready` held high, the port sustains one transfer per cycle with no bubbles after the first; a prefetch/skid register is required.
- `rd_valid` drops the cycle after the last transfer.
- Reset mid-operation: asynchronous return to reset values, including in READ. Partial readout is discarded.
- Sample arriving on the entry edge: an `in_valid` sample on the same edge as `arm` is not captured.

## Test plan
- **Basic capture.** DEPTH=16, PRE_TRIG=4, `trig_level`=0. Arm, then feed ramp −10,−9,…,+20 with `in_valid` every cycle, `rd_ready`=1. Required: 16 reads of −4…+11, `rd_last` on +11, `triggered`=1.
- **No trigger during fill.** Same setup, but the crossing (−1→0) occurs during PRE, then the signal stays ≥ 0 for 50 samples. Required: no trigger, state stays WAIT, `done`=0.
- **Forced trigger.** Pulse `force_trig` with a constant input of 5. Required: trigger on the next accepted sample; 16 samples of value 5 read out.
- **Wrap and backpressure.** Trigger after 37 WAIT samples; toggle `rd_ready` pseudo-randomly. Required: order is oldest-first across the wrap, each sample exactly once, `rd_data` held while stalled.
- **Gaps and edge parameters.** `in_valid` high 1 cycle in 3; also PRE_TRIG=0 and PRE_TRIG=15. Required: only strobed samples are stored; trigger sample is first, respectively last post-window sample.
- **Reset and arm handling.** Assert `emu_rst` during POST and mid-READ. Required: all outputs 0 immediately; a subsequent arm performs a clean capture. `arm` pulses during WAIT are ignored.

Source files
------------

// File: rtl/analog_trace_capture_if.sv
// Capture port bundle: probed sample input, trigger controls, status and the valid/ready readout.
interface analog_trace_capture_if #(
    parameter int unsigned WIDTH = 25
);
    logic signed [WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    arm;
    logic signed [WIDTH-1:0] trig_level;
    logic                    force_trig;
    logic signed [WIDTH-1:0] rd_data;
    logic                    rd_valid;
    logic                    rd_ready;
    logic                    rd_last;
    logic                    busy;
    logic                    triggered;
    logic                    done;

    modport slave (
        input  in_data, in_valid, arm, trig_level, force_trig, rd_ready,
        output rd_data, rd_valid, rd_last, busy, triggered, done
    );

    modport master (
        output in_data, in_valid, arm, trig_level, force_trig, rd_ready,
        input  rd_data, rd_valid, rd_last, busy, triggered, done
    );
endinterface

// File: rtl/analog_trace_capture.sv
// Trigger-based capture of a signed fixed-point probe: circular pre-trigger history,
// post-trigger fill, then oldest-first readout over a valid/ready port with a skid stage.
module analog_trace_capture #(
    parameter int unsigned WIDTH    = 25,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned PRE_TRIG = 64
) (
    input  logic                  emu_clk,
    input  logic                  emu_rst,
    analog_trace_capture_if.slave bus
);
    localparam int unsigned   AW          = $clog2(DEPTH);
    localparam logic [AW-1:0] ONE         = AW'(1);
    localparam logic [AW-1:0] PRE_W       = AW'(PRE_TRIG);
    localparam logic [AW-1:0] PRE_LAST    = AW'(PRE_TRIG - 1);
    localparam logic [AW-1:0] POST_INIT   = AW'(DEPTH - PRE_TRIG - 1);
    localparam logic [AW:0]   RD_ONE      = (AW+1)'(1);
    localparam logic [AW:0]   RD_TOTAL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   RD_LAST_IDX = (AW+1)'(DEPTH - 1);

    typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StRead} state_t;

    logic [WIDTH-1:0]        r_mem [DEPTH];
    state_t                  r_state, w_state;
    logic [AW-1:0]           r_wr_ptr, w_wr_ptr;
    logic [AW-1:0]           r_cnt, w_cnt;
    logic signed [WIDTH-1:0] r_prev, w_prev;
    logic                    r_prev_valid, w_prev_valid;
    logic                    r_triggered, w_triggered;
    logic                    r_force_pend, w_force_pend;
    logic [AW-1:0]           r_rd_addr, w_rd_addr;
    logic [AW:0]             r_rd_cnt, w_rd_cnt;
    logic [WIDTH-1:0]        r_ram_q;
    logic                    r_ram_vld, r_ram_last;
    logic [WIDTH-1:0]        r_out_data, w_out_data;
    logic                    r_out_valid, w_out_valid;
    logic                    r_out_last, w_out_last;
    logic [WIDTH-1:0]        r_skid_data, w_skid_data;
    logic                    r_skid_valid, w_skid_valid;
    logic                    r_skid_last, w_skid_last;
    logic                    w_ram_taken;

    logic                    w_accept;
    logic                    w_level_hit;
    logic                    w_trig;
    logic                    w_xfer;
    logic                    w_issue;
    logic [1:0]              w_occ;

    assign w_accept    = bus.in_valid &&
                         (r_state == StPre || r_state == StWait || r_state == StPost);
    assign w_level_hit = r_prev_valid && (r_prev < bus.trig_level) &&
                         (bus.in_data >= bus.trig_level);
    assign w_trig      = (r_state == StWait) && w_accept &&
                         (bus.force_trig || r_force_pend || w_level_hit);
    assign w_xfer      = r_out_valid && bus.rd_ready;
    // Entries held or in flight; a read is issued only if it will have a slot to land in.
    assign w_occ       = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_ram_vld);
    assign w_issue     = (r_state == StRead) && (r_rd_cnt != RD_TOTAL) &&
                         ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_xfer));

    always_comb begin
        w_state      = r_state;
        w_wr_ptr     = r_wr_ptr;
        w_cnt        = r_cnt;
        w_prev       = r_prev;
        w_prev_valid = r_prev_valid;
        w_triggered  = r_triggered;
        w_force_pend = r_force_pend;
        w_rd_addr    = r_rd_addr;
        w_rd_cnt     = r_rd_cnt;
        if (w_accept) begin
            w_wr_ptr     = r_wr_ptr + ONE;
            w_prev       = bus.in_data;
            w_prev_valid = 1'b1;
        end
        case (r_state)
            StIdle: begin
                if (bus.arm) begin
                    w_cnt        = '0;
                    w_prev_valid = 1'b0;
                    w_triggered  = 1'b0;
                    w_force_pend = 1'b0;
                    w_state      = (PRE_TRIG == 0) ? StWait : StPre;
                end
            end
            StPre: begin
                if (w_accept) begin
                    w_cnt = r_cnt + ONE;
                    if (r_cnt == PRE_LAST) w_state = StWait;
                end
            end
            StWait: begin
                if (w_trig) begin
                    w_triggered  = 1'b1;
                    w_force_pend = 1'b0;
                    // Window start is the trigger address minus the history length.
                    w_rd_addr    = r_wr_ptr - PRE_W;
                    w_rd_cnt     = '0;
                    w_cnt        = POST_INIT;
                    w_state      = (POST_INIT == '0) ? StRead : StPost;
                end else if (bus.force_trig) begin
                    w_force_pend = 1'b1;
                end
            end
            StPost: begin
                if (w_accept) begin
                    w_cnt = r_cnt - ONE;
                    if (r_cnt == ONE) w_state = StRead;
                end
            end
            StRead: begin
                if (w_issue) begin
                    w_rd_addr = r_rd_addr + ONE;
                    w_rd_cnt  = r_rd_cnt + RD_ONE;
                end
                if (w_xfer && r_out_last) w_state = StIdle;
            end
            default: w_state = StIdle;
        endcase
    end

    always_comb begin
        w_out_valid  = r_out_valid && !w_xfer;
        w_out_data   = r_out_data;
        w_out_last   = r_out_last;
        w_skid_valid = r_skid_valid;
        w_skid_data  = r_skid_data;
        w_skid_last  = r_skid_last;
        w_ram_taken  = 1'b0;
        if (!r_out_valid || w_xfer) begin
            if (r_skid_valid) begin
                w_out_data   = r_skid_data;
                w_out_last   = r_skid_last;
                w_out_valid  = 1'b1;
                w_skid_valid = 1'b0;
            end else if (r_ram_vld) begin
                w_out_data  = r_ram_q;
                w_out_last  = r_ram_last;
                w_out_valid = 1'b1;
                w_ram_taken = 1'b1;
            end
        end
        if (r_ram_vld && !w_ram_taken) begin
            w_skid_data  = r_ram_q;
            w_skid_last  = r_ram_last;
            w_skid_valid = 1'b1;
        end
    end

    always_ff @(posedge emu_clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= bus.in_data;
        if (w_issue)  r_ram_q <= r_mem[r_rd_addr];
    end

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            r_state      <= StIdle;
            r_wr_ptr     <= '0;
            r_cnt        <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_triggered  <= 1'b0;
            r_force_pend <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_cnt     <= '0;
            r_ram_vld    <= 1'b0;
            r_ram_last   <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_wr_ptr     <= w_wr_ptr;
            r_cnt        <= w_cnt;
            r_prev       <= w_prev;
            r_prev_valid <= w_prev_valid;
            r_triggered  <= w_triggered;
            r_force_pend <= w_force_pend;
            r_rd_addr    <= w_rd_addr;
            r_rd_cnt     <= w_rd_cnt;
            r_ram_vld    <= w_issue;
            r_ram_last   <= w_issue && (r_rd_cnt == RD_LAST_IDX);
            r_out_data   <= w_out_data;
            r_out_valid  <= w_out_valid;
            r_out_last   <= w_out_last;
            r_skid_data  <= w_skid_data;
            r_skid_valid <= w_skid_valid;
            r_skid_last  <= w_skid_last;
        end
    end

    assign bus.rd_data   = r_out_data;
    assign bus.rd_valid  = r_out_valid;
    assign bus.rd_last   = r_out_last;
    assign bus.busy      = (r_state != StIdle);
    assign bus.triggered = r_triggered;
    assign bus.done      = (r_state == StRead);
endmodule

// File: tb/tb_analog_trace_capture.sv
// Bench for analog_trace_capture: three instances (PRE_TRIG 4, 0, 15) share one stimulus and are
// checked against a sample-sequence reference model of the capture window.
module tb_analog_trace_capture;
    localparam int W  = 25;
    localparam int D  = 16;
    localparam int NI = 3;
    localparam int P [NI] = '{4, 0, 15};

    logic emu_clk = 1'b0;
    logic emu_rst = 1'b1;
    logic signed [W-1:0] d_data = '0;
    logic signed [W-1:0] d_level = '0;
    logic d_valid = 1'b0, d_arm = 1'b0, d_force = 1'b0, d_ready = 1'b1;

    logic [W-1:0] o_data [NI];
    logic o_valid [NI], o_last [NI], o_busy [NI], o_trig [NI], o_done [NI];

    always #5 emu_clk = ~emu_clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        analog_trace_capture_if #(.WIDTH(W)) u_if ();
        assign u_if.in_data    = d_data;
        assign u_if.in_valid   = d_valid;
        assign u_if.arm        = d_arm;
        assign u_if.trig_level = d_level;
        assign u_if.force_trig = d_force;
        assign u_if.rd_ready   = d_ready;
        assign o_data[g]  = u_if.rd_data;
        assign o_valid[g] = u_if.rd_valid;
        assign o_last[g]  = u_if.rd_last;
        assign o_busy[g]  = u_if.busy;
        assign o_trig[g]  = u_if.triggered;
        assign o_done[g]  = u_if.done;
        analog_trace_capture #(.WIDTH(W), .DEPTH(D), .PRE_TRIG(P[g])) u_dut (
            .emu_clk (emu_clk),
            .emu_rst (emu_rst),
            .bus     (u_if)
        );
    end

    int checks = 0;
    int errors = 0;
    int smp[$];
    bit frc_q[$];
    int lvl = 0;
    bit rnd_ready = 1'b0;
    int base_n [NI];
    int base_sv [NI];

    // Transfer log and stall-stability watch, sampled on the falling edge.
    int got_n [NI] = '{0, 0, 0};
    int got_data [NI][512];
    bit got_last [NI][512];
    int stall_viol [NI] = '{0, 0, 0};
    bit hold_p [NI] = '{0, 0, 0};
    logic [W-1:0] hold_d [NI];
    logic hold_l [NI];

    always @(negedge emu_clk) begin
        for (int g = 0; g < NI; g++) begin
            if (emu_rst) begin
                hold_p[g] = 1'b0;
            end else begin
                if (hold_p[g] && (o_valid[g] !== 1'b1 || o_data[g] !== hold_d[g] ||
                                  o_last[g] !== hold_l[g]))
                    stall_viol[g]++;
                hold_p[g] = o_valid[g] && !d_ready;
                hold_d[g] = o_data[g];
                hold_l[g] = o_last[g];
                if (o_valid[g] && d_ready) begin
                    got_data[g][got_n[g] % 512] = int'($signed(o_data[g]));
                    got_last[g][got_n[g] % 512] = o_last[g];
                    got_n[g]++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // First accepted-sample index (at or after the history fill) that meets the trigger rule.
    function automatic int model_trig(input int p);
        for (int t = p; t < smp.size(); t++)
            if (frc_q[t] || (t > 0 && smp[t-1] < lvl && smp[t] >= lvl)) return t;
        return -1;
    endfunction

    task automatic cyc();
        @(posedge emu_clk);
        #1;
        if (rnd_ready) d_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic feed(input int v, input bit vld, input bit f);
        d_data  = W'(v);
        d_valid = vld;
        d_force = f;
        if (vld) begin
            smp.push_back(v);
            frc_q.push_back(f);
        end
        cyc();
        d_valid = 1'b0;
        d_force = 1'b0;
    endtask

    task automatic ramp();
        for (int v = -10; v <= 20; v++) feed(v, 1'b1, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("%s_valid_g%0d", tag, g), o_valid[g], 0);
            chk($sformatf("%s_last_g%0d", tag, g), o_last[g], 0);
            chk($sformatf("%s_data_g%0d", tag, g), $signed(o_data[g]), 0);
            chk($sformatf("%s_busy_g%0d", tag, g), o_busy[g], 0);
            chk($sformatf("%s_trig_g%0d", tag, g), o_trig[g], 0);
            chk($sformatf("%s_done_g%0d", tag, g), o_done[g], 0);
        end
    endtask

    task automatic do_arm();
        d_level = W'(lvl);
        d_arm   = 1'b1;
        d_valid = 1'b1;
        d_data  = W'(999);
        cyc();
        d_arm   = 1'b0;
        d_valid = 1'b0;
        smp.delete();
        frc_q.delete();
        for (int g = 0; g < NI; g++) begin
            base_n[g]  = got_n[g];
            base_sv[g] = stall_viol[g];
            chk($sformatf("busy_after_arm_g%0d", g), o_busy[g], 1);
        end
    endtask

    task automatic do_reset(input string tag);
        #2 emu_rst = 1'b1;
        #1 chk_zero(tag);
        @(negedge emu_clk);
        #1 emu_rst = 1'b0;
        cyc();
    endtask

    task automatic finish_capture(input string tag);
        bit all_done;
        int cycles = 0;
        d_valid = 1'b0;
        do begin
            all_done = 1'b1;
            for (int g = 0; g < NI; g++) begin
                int t = model_trig(P[g]);
                if (t >= 0 && t - P[g] + D <= smp.size() && o_busy[g]) all_done = 1'b0;
            end
            if (!all_done) cyc();
            cycles++;
        end while (!all_done && cycles < 600);
        chk({tag, "_timeout"}, all_done, 1);
        for (int g = 0; g < NI; g++) begin
            int t = model_trig(P[g]);
            int n = got_n[g] - base_n[g];
            if (t < 0) begin
                chk($sformatf("%s_notrig_busy_g%0d", tag, g), o_busy[g], 1);
                chk($sformatf("%s_notrig_trig_g%0d", tag, g), o_trig[g], 0);
                chk($sformatf("%s_notrig_done_g%0d", tag, g), o_done[g], 0);
                chk($sformatf("%s_notrig_reads_g%0d", tag, g), n, 0);
            end else if (t - P[g] + D > smp.size()) begin
                chk($sformatf("%s_partial_busy_g%0d", tag, g), o_busy[g], 1);
                chk($sformatf("%s_partial_trig_g%0d", tag, g), o_trig[g], 1);
            end else begin
                chk($sformatf("%s_busy_g%0d", tag, g), o_busy[g], 0);
                chk($sformatf("%s_trig_g%0d", tag, g), o_trig[g], 1);
                chk($sformatf("%s_valid_g%0d", tag, g), o_valid[g], 0);
                chk($sformatf("%s_reads_g%0d", tag, g), n, D);
                for (int k = 0; k < D && k < n; k++) begin
                    int idx = (base_n[g] + k) % 512;
                    chk($sformatf("%s_data_g%0d_k%0d", tag, g, k), got_data[g][idx],
                        smp[t - P[g] + k]);
                    chk($sformatf("%s_last_g%0d_k%0d", tag, g, k), got_last[g][idx],
                        (k == D - 1) ? 1 : 0);
                end
            end
            chk($sformatf("%s_stall_g%0d", tag, g), stall_viol[g] - base_sv[g], 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge emu_clk);
        chk_zero("reset");
        #1 emu_rst = 1'b0;
        cyc();

        // Ramp through zero; PRE_TRIG=15 sees the crossing during its fill.
        lvl = 0;
        do_arm();
        ramp();
        finish_capture("basic");
        do_reset("rst1");

        // Crossing inside the PRE_TRIG=4 fill, then non-negative for 50 samples.
        lvl = 0;
        do_arm();
        for (int v = -3; v <= -1; v++) feed(v, 1'b1, 1'b0);
        for (int v = 0; v < 50; v++) feed(v, 1'b1, 1'b0);
        finish_capture("fill");
        do_reset("rst2");

        // Forced trigger on constant input.
        lvl = 100;
        do_arm();
        for (int i = 0; i < 40; i++) feed(5, 1'b1, i == 20);
        finish_capture("force");
        do_reset("rst3");

        // Long wait wraps the buffer; random readout backpressure.
        lvl = 2000;
        rnd_ready = 1'b1;
        do_arm();
        for (int i = 0; i < 70; i++)
            feed(int'($urandom_range(0, 2000)) - 1000, 1'b1, i == 52);
        finish_capture("wrap");
        do_reset("rst4");

        // Sparse strobes with junk between them; an arm pulse mid-capture must be ignored.
        lvl = 0;
        do_arm();
        for (int i = 0; i < 240; i++) begin
            if (i == 31) d_arm = 1'b1;
            if (i % 3 == 0) feed(int'($urandom_range(0, 100)) - 50, 1'b1, 1'b0);
            else feed(7777, 1'b0, 1'b0);
            d_arm = 1'b0;
        end
        finish_capture("gaps");
        do_reset("rst5");

        // Reset while filling the post-trigger window, then a clean capture.
        rnd_ready = 1'b0;
        d_ready = 1'b1;
        lvl = 100;
        do_arm();
        for (int i = 0; i < 24; i++) feed(i, 1'b1, i == 20);
        for (int g = 0; g < NI; g++) chk($sformatf("post_trig_g%0d", g), o_trig[g], 1);
        do_reset("rst_post");
        lvl = 0;
        do_arm();
        ramp();
        finish_capture("after_post_rst");
        do_reset("rst6");

        // Reset part-way through a backpressured readout, then a clean capture.
        rnd_ready = 1'b1;
        lvl = 100;
        do_arm();
        for (int i = 0; i < 31; i++) feed(i * 3 - 7, 1'b1, i == 18);
        begin
            int cycles = 0;
            while (got_n[0] - base_n[0] < 5 && cycles < 200) begin
                cyc();
                cycles++;
            end
            chk("midread_timeout", (got_n[0] - base_n[0] >= 5) ? 1 : 0, 1);
        end
        chk("midread_done", o_done[0], 1);
        do_reset("rst_read");
        lvl = 0;
        do_arm();
        ramp();
        finish_capture("after_read_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
